// File: rtl/wb_skid_buffer.sv
// MEM->WB pipeline register with a one-entry skid slot, so in_ready comes
// straight from a flop and never combinationally from out_ready.
module wb_skid_buffer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int HAS_HILO   = 1,
  parameter int SQUASH_R0  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_write_enable,
  input  logic [ADDR_WIDTH-1:0] in_write_addr,
  input  logic [DATA_WIDTH-1:0] in_write_data,
  input  logic                  in_write_hilo_enable,
  input  logic [DATA_WIDTH-1:0] in_write_hi_data,
  input  logic [DATA_WIDTH-1:0] in_write_lo_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_write_enable,
  output logic [ADDR_WIDTH-1:0] out_write_addr,
  output logic [DATA_WIDTH-1:0] out_write_data,
  output logic                  out_write_hilo_enable,
  output logic [DATA_WIDTH-1:0] out_write_hi_data,
  output logic [DATA_WIDTH-1:0] out_write_lo_data,
  output logic [1:0]            occupancy
);

  localparam logic HILO_ON   = (HAS_HILO != 0);
  localparam logic SQUASH_ON = (SQUASH_R0 != 0);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  hen;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
  } entry_t;

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and in_ready depends only on skid_valid_q.
  entry_t head_q, head_d, skid_q, skid_d, cap;
  logic   head_valid_q, head_valid_d, skid_valid_q, skid_valid_d;
  logic   accept, pop, head_load;

  assign in_ready  = !skid_valid_q;
  assign out_valid = head_valid_q;
  assign accept    = in_valid && in_ready;
  assign pop       = head_valid_q && out_ready;
  assign head_load = !head_valid_q || pop;

  // Writes to r0 are kept in the pipe (the instruction still retires) but never write.
  always_comb begin
    cap.we   = in_write_enable && !(SQUASH_ON && (in_write_addr == '0));
    cap.addr = in_write_addr;
    cap.data = in_write_data;
    cap.hen  = HILO_ON && in_write_hilo_enable;
    cap.hi   = HILO_ON ? in_write_hi_data : '0;
    cap.lo   = HILO_ON ? in_write_lo_data : '0;
  end

  always_comb begin
    head_d       = head_q;
    head_valid_d = head_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (head_load) begin
      if (skid_valid_q) begin
        head_d       = skid_q;
        head_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        head_d       = cap;
        head_valid_d = 1'b1;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = cap;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q       <= '0;
      skid_q       <= '0;
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      skid_q       <= skid_d;
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // The skid slot is only ever valid while the head is valid.
  assign occupancy             = {head_valid_q & skid_valid_q, head_valid_q ^ skid_valid_q};
  assign out_write_enable      = head_q.we && head_valid_q;
  assign out_write_hilo_enable = head_q.hen && head_valid_q;
  assign out_write_addr        = head_q.addr;
  assign out_write_data        = head_q.data;
  assign out_write_hi_data     = head_q.hi;
  assign out_write_lo_data     = head_q.lo;

endmodule
